// File: rtl/mul_pkg.sv
// Shared types for the LEGv8 MUL sequencer: controller states and ALUSrc operand-B encodings.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] ALUSRC_REG    = 3'b000;
   localparam logic [2:0] ALUSRC_IMM    = 3'b001;
   localparam logic [2:0] ALUSRC_SHIFT  = 3'b010;
   localparam logic [2:0] ALUSRC_MULT   = 3'b011;
   localparam logic [2:0] ALUSRC_DTADDR = 3'b100;

endpackage

// File: rtl/mul_step.sv
// One shift-add partial-product step: acc + a * b_slice, truncated to WIDTH. Purely combinational.
module mul_step #(
   parameter int WIDTH          = 64,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [WIDTH-1:0]          acc,
   input  logic [WIDTH-1:0]          a,
   input  logic [BITS_PER_CYCLE-1:0] b_slice,
   output logic [WIDTH-1:0]          acc_next
);

   always_comb begin
      acc_next = acc;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (b_slice[i]) acc_next = acc_next + (a << i);
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative LEGv8 MUL controller: stalls EX for WIDTH/BITS_PER_CYCLE RUN cycles, then a one-cycle DONE forces ALUSrc to the product.
// MUL_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module mul_sequencer
   import mul_pkg::*;
#(
   parameter int WIDTH          = 64,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [2:0]       alu_src_in,
   output logic [2:0]       alu_src_out,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] multRes
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   mult_res_q, mult_res_d;
   logic [WIDTH-1:0]   acc_step;
   logic               last_step;

   mul_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .acc      (acc_q),
      .a        (a_q),
      .b_slice  (b_q[BITS_PER_CYCLE-1:0]),
      .acc_next (acc_step)
   );

`ifdef MUL_EARLY_EXIT_EN
   assign last_step = (count_q == CNT_W'(N - 1)) || ((b_q >> BITS_PER_CYCLE) == '0);
`else
   assign last_step = (count_q == CNT_W'(N - 1));
`endif

   assign multRes = mult_res_q;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      a_d         = a_q;
      b_d         = b_q;
      count_d     = count_q;
      mult_res_d  = mult_res_q;
      stall       = 1'b0;
      done        = 1'b0;
      alu_src_out = alu_src_in;

      case (state_q)
         IDLE: begin
            // Stall is combinational so the MUL holds in EX from the very cycle it arrives.
            stall = start & ~flush;
            if (start && !flush) begin
               a_d     = opA;
               b_d     = opB;
               acc_d   = '0;
               count_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               stall   = 1'b1;
               acc_d   = acc_step;
               a_d     = a_q << BITS_PER_CYCLE;
               b_d     = b_q >> BITS_PER_CYCLE;
               count_d = count_q + 1'b1;
               if (last_step) begin
                  state_d    = DONE;
                  mult_res_d = acc_step;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!flush) begin
               done        = 1'b1;
               alu_src_out = ALUSRC_MULT;
            end
         end
         default: state_d = IDLE;
      endcase

      if (reset) begin
         stall       = 1'b0;
         done        = 1'b0;
         alu_src_out = alu_src_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         count_q    <= '0;
         mult_res_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         a_q        <= a_d;
         b_q        <= b_d;
         count_q    <= count_d;
         mult_res_q <= mult_res_d;
      end
   end

endmodule
